muldiv_sequencer: RTL and testbench

- Controller between the execute stage and the shared multi-cycle M-extension unit.
- Captures one MUL/DIV/REM request and holds its operands stable while the unit runs.
- Pulses the unit's start, stalls the pipeline until the result returns, and handles flushes.
- Resolves RISC-V divide-by-zero and signed-overflow cases directly, without starting the divider.

---
 rtl/muldiv_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Sequencer between EX and the shared multi-cycle M-extension unit.
// Ports: clk, rst (sync, active high); EX side ex_valid/ex_op/ex_a/ex_b,
//   flush, stall, result_valid, result; unit side md_start/md_op/md_a/
//   md_b, md_resp/md_result; timeout_err (sticky).
// Optional: MULDIV_RESULT_CACHE_EN adds a one-entry result cache.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        flush,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_resp,
  input  logic [31:0] md_result,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_DRAIN
  } state_t;

  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_REM = 3'd6;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_md_start;
  logic [2:0]  r_md_op;
  logic [31:0] r_md_a;
  logic [31:0] r_md_b;
  logic [31:0] r_result;
  logic        r_tmo;
  logic [CNT_W-1:0] r_cnt;

  logic        w_accept;
  logic        w_b_zero;
  logic        w_ovf;
  logic        w_is_div;
  logic        w_is_rem;
  logic        w_fast;
  logic [31:0] w_fast_val;
  logic        w_hit;
  logic [31:0] w_cval;
  logic        w_resp;
  logic [CNT_W-1:0] w_cnt_inc;
  logic        w_tmo;
  logic        w_start;
  logic        w_load;
  logic [31:0] w_res_nxt;
  logic        w_set_tmo;

  assign w_accept  = (r_state == S_IDLE) & ex_valid & ~flush;
  assign w_b_zero  = (ex_b == 32'h0);
  assign w_ovf     = (ex_a == 32'h8000_0000) & (ex_b == 32'hFFFF_FFFF);
  assign w_is_div  = ex_op[2] & ~ex_op[1];
  assign w_is_rem  = ex_op[2] & ex_op[1];
  // md_resp is meaningless while the start pulse is still out
  assign w_resp    = md_resp & ~r_md_start;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_tmo     = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // RISC-V defined results that never need the divider
  always_comb begin
    w_fast     = 1'b0;
    w_fast_val = 32'h0;
    unique case (1'b1)
      (w_is_div & w_b_zero): begin
        w_fast     = 1'b1;
        w_fast_val = 32'hFFFF_FFFF;
      end
      (w_is_rem & w_b_zero): begin
        w_fast     = 1'b1;
        w_fast_val = ex_a;
      end
      ((ex_op == OP_DIV) & w_ovf): begin
        w_fast     = 1'b1;
        w_fast_val = 32'h8000_0000;
      end
      ((ex_op == OP_REM) & w_ovf): begin
        w_fast     = 1'b1;
        w_fast_val = 32'h0;
      end
      default: ;
    endcase
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic [66:0] r_tag;
  logic [31:0] r_cval;
  logic        r_cvld;
  logic        r_tmo_done;
  logic        w_inval;

  assign w_hit   = r_cvld & (r_tag == {ex_op, ex_a, ex_b});
  assign w_cval  = r_cval;
  assign w_inval = w_set_tmo
                 | (flush & ((r_state == S_BUSY)
                           | (r_state == S_DRAIN)));

  // r_tmo_done marks a DONE entered by timeout; that zero is not cached
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag      <= '0;
      r_cval     <= '0;
      r_cvld     <= 1'b0;
      r_tmo_done <= 1'b0;
    end else begin
      r_tmo_done <= w_set_tmo;
      if (w_inval) begin
        r_cvld <= 1'b0;
      end else if ((r_state == S_DONE) & ~flush & ~r_tmo_done) begin
        r_cvld <= 1'b1;
        r_tag  <= {r_md_op, r_md_a, r_md_b};
        r_cval <= r_result;
      end
    end
  end
`else
  assign w_hit  = 1'b0;
  assign w_cval = 32'h0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_res_nxt   = 32'h0;
    w_set_tmo   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fast) begin
            w_state_nxt = S_DONE;
            w_load      = 1'b1;
            w_res_nxt   = w_fast_val;
          end else if (w_hit) begin
            w_state_nxt = S_DONE;
            w_load      = 1'b1;
            w_res_nxt   = w_cval;
          end else begin
            w_state_nxt = S_BUSY;
            w_start     = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (w_resp & flush) begin
          w_state_nxt = S_IDLE;
        end else if (w_resp) begin
          w_state_nxt = S_DONE;
          w_load      = 1'b1;
          w_res_nxt   = md_result;
        end else if (w_tmo) begin
          w_set_tmo = 1'b1;
          if (flush) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
            w_load      = 1'b1;
          end
        end else if (flush) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        // unit cannot be aborted: wait it out, drop its result
        if (w_resp) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmo) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_md_start <= 1'b0;
      r_md_op    <= 3'h0;
      r_md_a     <= 32'h0;
      r_md_b     <= 32'h0;
      r_result   <= 32'h0;
      r_tmo      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_md_start <= w_start;
      if (w_accept) begin
        r_md_op <= ex_op;
        r_md_a  <= ex_a;
        r_md_b  <= ex_b;
      end
      if (w_load) begin
        r_result <= w_res_nxt;
      end
      if (w_set_tmo) begin
        r_tmo <= 1'b1;
      end
      if ((r_state == S_BUSY) | (r_state == S_DRAIN)) begin
        r_cnt <= w_cnt_inc;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign stall = ex_valid
               & ((~flush & (r_state != S_DONE))
                | (r_state == S_DRAIN));
  assign result_valid = (r_state == S_DONE) & ~flush;
  assign result       = r_result;
  assign md_start     = r_md_start;
  assign md_op        = r_md_op;
  assign md_a         = r_md_a;
  assign md_b         = r_md_b;
  assign timeout_err  = r_tmo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer.
// Inputs change after negedge; outputs are checked 1ns later.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        flush;
  logic        stall;
  logic        result_valid;
  logic [31:0] result;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_resp;
  logic [31:0] md_result;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  int          n_st, st_c, n_stl, rv_c, n_rv, tm_c;
  logic [31:0] rv_r;

  muldiv_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_a         (ex_a),
    .ex_b         (ex_b),
    .flush        (flush),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .md_start     (md_start),
    .md_op        (md_op),
    .md_a         (md_a),
    .md_b         (md_b),
    .md_resp      (md_resp),
    .md_result    (md_result),
    .timeout_err  (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one instruction: ex_valid held until result_valid is seen;
  // the unit model answers in cycle resp_at (relative to accept)
  task automatic run_op(input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int resp_at,
                        input logic [31:0] rval,
                        input int maxc,
                        output int nstart, output int start_c,
                        output int nstall, output int rvc,
                        output logic [31:0] rvres,
                        output int nrv, output int tmc);
    bit held;
    held    = 1'b1;
    nstart  = 0;
    start_c = -1;
    nstall  = 0;
    rvc     = -1;
    rvres   = 32'h0;
    nrv     = 0;
    tmc     = -1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      ex_valid  = held;
      ex_op     = op;
      ex_a      = a;
      ex_b      = b;
      md_resp   = (c == resp_at);
      md_result = (c == resp_at) ? rval : 32'h0;
      #1;
      if (md_start) begin
        nstart++;
        if (start_c < 0) start_c = c;
      end
      if (stall) nstall++;
      if (timeout_err && tmc < 0) tmc = c;
      if (result_valid) begin
        nrv++;
        if (rvc < 0) begin
          rvc   = c;
          rvres = result;
        end
        held = 1'b0;
      end
    end
    ex_valid = 1'b0;
    md_resp  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ex_valid  = 1'b0;
    ex_op     = 3'd0;
    ex_a      = 32'h0;
    ex_b      = 32'h0;
    flush     = 1'b0;
    md_resp   = 1'b0;
    md_result = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_rv", {31'h0, result_valid}, 32'h0);
    chk("rst_start", {31'h0, md_start}, 32'h0);
    chk("rst_tmo", {31'h0, timeout_err}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_md_op", {29'h0, md_op}, 32'h0);
    chk("rst_md_a", md_a, 32'h0);
    chk("rst_md_b", md_b, 32'h0);
    rst = 1'b0;

    // MUL 7 * -6, unit answers 4 cycles after accept
    run_op(3'd0, 32'd7, 32'hFFFF_FFFA, 4, 32'hFFFF_FFD6, 8,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("mul_nstart", n_st, 32'd1);
    chk("mul_start_c", st_c, 32'd1);
    chk("mul_nstall", n_stl, 32'd5);
    chk("mul_rv_c", rv_c, 32'd5);
    chk("mul_nrv", n_rv, 32'd1);
    chk("mul_res", rv_r, 32'hFFFF_FFD6);
    chk("mul_md_a", md_a, 32'd7);

    // fast paths
    run_op(3'd5, 32'd100, 32'h0, -1, 32'h0, 4,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("divu0_nstart", n_st, 32'd0);
    chk("divu0_rv_c", rv_c, 32'd1);
    chk("divu0_res", rv_r, 32'hFFFF_FFFF);
    chk("divu0_nstall", n_stl, 32'd1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h0, 4,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("removf_nstart", n_st, 32'd0);
    chk("removf_rv_c", rv_c, 32'd1);
    chk("removf_res", rv_r, 32'h0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1, 32'h0, 4,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("divovf_nstart", n_st, 32'd0);
    chk("divovf_res", rv_r, 32'h8000_0000);
    run_op(3'd7, 32'h1234_5678, 32'h0, -1, 32'h0, 4,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("remu0_res", rv_r, 32'h1234_5678);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h0, 6,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("divu_noovf_nstart", n_st, 32'd1);

    // flush in DONE suppresses result_valid
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'd7; ex_a = 32'd9; ex_b = 32'd0;
    #1;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("dflush_rv", {31'h0, result_valid}, 32'h0);
    chk("dflush_stall", {31'h0, stall}, 32'h0);
    chk("dflush_res", result, 32'd9);
    @(negedge clk);
    flush = 1'b0; ex_valid = 1'b0;
    #1;

    // flush in BUSY -> DRAIN; next op waits for the drain
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'd4; ex_a = 32'd100; ex_b = 32'd7;
    #1;
    chk("fl_acc_stall", {31'h0, stall}, 32'h1);
    @(negedge clk); #1;
    chk("fl_start", {31'h0, md_start}, 32'h1);
    @(negedge clk); #1;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_stall0", {31'h0, stall}, 32'h0);
    @(negedge clk);
    flush = 1'b0;
    ex_op = 3'd0; ex_a = 32'd9; ex_b = 32'd9;
    #1;
    chk("drain_stall", {31'h0, stall}, 32'h1);
    chk("drain_md_a", md_a, 32'd100);
    @(negedge clk); #1;
    chk("drain_rv", {31'h0, result_valid}, 32'h0);
    @(negedge clk);
    md_resp = 1'b1; md_result = 32'd14;
    #1;
    chk("drain_resp_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    md_resp = 1'b0; md_result = 32'h0;
    #1;
    chk("readmit_rv", {31'h0, result_valid}, 32'h0);
    chk("readmit_start", {31'h0, md_start}, 32'h0);
    chk("readmit_stall", {31'h0, stall}, 32'h1);
    @(negedge clk); #1;
    chk("readmit_start1", {31'h0, md_start}, 32'h1);
    chk("readmit_md_a", md_a, 32'd9);
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk);
    md_resp = 1'b1; md_result = 32'd81;
    #1;
    chk("second_rv0", {31'h0, result_valid}, 32'h0);
    @(negedge clk);
    md_resp = 1'b0; md_result = 32'h0;
    #1;
    chk("second_rv", {31'h0, result_valid}, 32'h1);
    chk("second_res", result, 32'd81);
    chk("second_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    ex_valid = 1'b0;
    #1;

    // unit never answers
    run_op(3'd4, 32'd50, 32'd3, -1, 32'h0, 70,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("tmo_nstart", n_st, 32'd1);
    chk("tmo_c", tm_c, 32'd65);
    chk("tmo_rv_c", rv_c, 32'd65);
    chk("tmo_res", rv_r, 32'h0);
    chk("tmo_nrv", n_rv, 32'd1);
    chk("tmo_sticky", {31'h0, timeout_err}, 32'h1);

    // reset while BUSY
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'd4; ex_a = 32'd77; ex_b = 32'd5;
    #1;
    @(negedge clk); #1;
    chk("rb_start", {31'h0, md_start}, 32'h1);
    chk("rb_tmo_held", {31'h0, timeout_err}, 32'h1);
    @(negedge clk);
    ex_valid = 1'b0; rst = 1'b1;
    #1;
    @(negedge clk); #1;
    chk("rb_stall", {31'h0, stall}, 32'h0);
    chk("rb_rv", {31'h0, result_valid}, 32'h0);
    chk("rb_start0", {31'h0, md_start}, 32'h0);
    chk("rb_tmo", {31'h0, timeout_err}, 32'h0);
    chk("rb_result", result, 32'h0);
    chk("rb_md_op", {29'h0, md_op}, 32'h0);
    chk("rb_md_a", md_a, 32'h0);
    chk("rb_md_b", md_b, 32'h0);
    rst = 1'b0;
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, 4, 32'd1, 8,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("mulhu_nstart", n_st, 32'd1);
    chk("mulhu_rv_c", rv_c, 32'd5);
    chk("mulhu_res", rv_r, 32'd1);

    // repeated MUL 3*5
    run_op(3'd0, 32'd3, 32'd5, 4, 32'd15, 8,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("rep1_nstart", n_st, 32'd1);
    chk("rep1_res", rv_r, 32'd15);
    run_op(3'd0, 32'd3, 32'd5, 4, 32'd15, 8,
           n_st, st_c, n_stl, rv_c, rv_r, n_rv, tm_c);
    chk("rep2_res", rv_r, 32'd15);
`ifdef MULDIV_RESULT_CACHE_EN
    chk("rep2_nstart", n_st, 32'd0);
    chk("rep2_rv_c", rv_c, 32'd1);
`else
    chk("rep2_nstart", n_st, 32'd1);
    chk("rep2_rv_c", rv_c, 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
